// File: rtl/xcore_fifo_pkg.sv
// Shared types and defaults for the packet write controller of the async FIFO.
// Provides the write-controller state enum, default pointer width / depth and
// the statistics counter width.
package xcore_fifo_pkg;

    localparam int FIFO_PTR_DEF   = 6;
    localparam int FIFO_DEPTH_DEF = 1 << FIFO_PTR_DEF;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PKT   = 3'd1,
        ST_DROP  = 3'd2,
        ST_RB    = 3'd3,
        ST_FLUSH = 3'd4
    } wr_state_e;

endpackage

// File: rtl/xcore_sat_cnt.sv
// Saturating event counter: counts i_inc pulses and holds at all-ones.
// Ports: i_clk_w / i_rst_w (async active-low), i_inc, o_cnt (registered).
// Latency: o_cnt reflects an increment one cycle after i_inc; no backpressure.
module xcore_sat_cnt #(
    parameter int W = 16
) (
    input  logic         i_clk_w,
    input  logic         i_rst_w,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    always_ff @(posedge i_clk_w or negedge i_rst_w) begin
        if (!i_rst_w) begin
            o_cnt <= '0;
        end else if (i_inc && (o_cnt != {W{1'b1}})) begin
            o_cnt <= o_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/xcore_fifo_pkt_wr_ctrl.sv
// Write-side packet controller for the async FIFO: writes framed packets, snapshots
// the write pointer at SOP, rolls it back on error/oversize, resets it on flush.
// Ports: upstream valid/ready beat interface (sop/eop/err/data), FIFO write-port
// controls, commit/drop pulses, saturating commit/drop counters, busy.
// Latency: accepted beat reaches o_fifo_write_en/o_fifo_data one cycle later.
// Backpressure: o_pkt_ready (combinational) honours FIFO full and a room estimate
// that discounts the last two writes; DROP always accepts, RB/FLUSH never do.
// Build option: XCORE_PKT_MAXLEN_CHK_EN limits packets to MAX_PKT_LEN beats.
module xcore_fifo_pkt_wr_ctrl
    import xcore_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH  = 32,
    parameter int FIFO_PTR    = FIFO_PTR_DEF,
    parameter int MAX_PKT_LEN = 32,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                  i_clk_w,
    input  logic                  i_rst_w,
    input  logic                  i_pkt_valid,
    input  logic                  i_pkt_sop,
    input  logic                  i_pkt_eop,
    input  logic                  i_pkt_err,
    input  logic [FIFO_WIDTH-1:0] i_pkt_data,
    output logic                  o_pkt_ready,
    input  logic                  i_flush,
    input  logic                  i_fifo_full,
    input  logic [FIFO_PTR:0]     i_fifo_room_avail,
    output logic                  o_fifo_write_en,
    output logic [FIFO_WIDTH-1:0] o_fifo_data,
    output logic                  o_fifo_snapshot_wrptr,
    output logic                  o_fifo_rollback_wrptr,
    output logic                  o_fifo_reset_wrptr,
    output logic                  o_pkt_commit,
    output logic                  o_pkt_drop,
    output logic [CNT_W-1:0]      o_commit_cnt,
    output logic [CNT_W-1:0]      o_drop_cnt,
    output logic                  o_busy
);

    localparam int DEPTH = 1 << FIFO_PTR;
`ifdef XCORE_PKT_MAXLEN_CHK_EN
    localparam int LEN_LIMIT = MAX_PKT_LEN;
`else
    localparam int LEN_LIMIT = DEPTH;
`endif
    localparam logic [FIFO_PTR:0] LEN_LIM = LEN_LIMIT[FIFO_PTR:0];

    if ((MAX_PKT_LEN < 1) || (MAX_PKT_LEN > DEPTH)) begin : g_bad_max_len
        $error("MAX_PKT_LEN out of range 1..2^FIFO_PTR");
    end

    wr_state_e state, state_nxt;

    logic [FIFO_PTR:0] len, len_nxt;
    logic              acc_d2;
    // Open packet already counted as a drop with nothing to roll back; its
    // remaining beats are discarded silently.
    logic              counted, counted_nxt;
    logic              flush_to_drop, to_drop_nxt;
    logic              wr_nxt, snap_nxt, rb_nxt, rst_nxt, commit_nxt, drop_nxt;
    logic [FIFO_PTR:0] acc_sum;
    logic              room_ok;
    logic              accept;

    // The FIFO room status lags writes by two cycles; discount writes still in flight.
    assign acc_sum = {{FIFO_PTR{1'b0}}, o_fifo_write_en} + {{FIFO_PTR{1'b0}}, acc_d2};
    assign room_ok = !i_fifo_full && (i_fifo_room_avail > acc_sum);

    always_comb begin
        o_pkt_ready = 1'b0;
        case (state)
            ST_IDLE, ST_PKT: o_pkt_ready = room_ok;
            ST_DROP:         o_pkt_ready = 1'b1;
            default:         o_pkt_ready = 1'b0;
        endcase
    end

    assign accept = i_pkt_valid && o_pkt_ready;

    always_comb begin
        state_nxt   = state;
        len_nxt     = len;
        counted_nxt = counted;
        to_drop_nxt = flush_to_drop;
        wr_nxt      = 1'b0;
        snap_nxt    = 1'b0;
        rb_nxt      = 1'b0;
        rst_nxt     = 1'b0;
        commit_nxt  = 1'b0;
        drop_nxt    = 1'b0;
        if (i_flush) begin
            // Pointer reset discards any partial packet, so no rollback follows.
            state_nxt   = ST_FLUSH;
            rst_nxt     = 1'b1;
            counted_nxt = 1'b1;
            if (state != ST_FLUSH) begin
                to_drop_nxt = (state == ST_PKT) || (state == ST_DROP);
            end
            drop_nxt = (state == ST_PKT) || ((state == ST_DROP) && !counted);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        counted_nxt = 1'b0;
                        if (i_pkt_sop && !i_pkt_err) begin
                            wr_nxt   = 1'b1;
                            snap_nxt = 1'b1;
                            len_nxt  = {{FIFO_PTR{1'b0}}, 1'b1};
                            if (i_pkt_eop) commit_nxt = 1'b1;
                            else           state_nxt  = ST_PKT;
                        end else begin
                            // Errored SOP or stray beat: nothing written, nothing
                            // snapshotted, so the drop is counted now and no
                            // rollback is issued later.
                            drop_nxt = 1'b1;
                            if (i_pkt_sop && !i_pkt_eop) begin
                                state_nxt   = ST_DROP;
                                counted_nxt = 1'b1;
                            end
                        end
                    end
                end
                ST_PKT: begin
                    if (accept) begin
                        if (i_pkt_err || i_pkt_sop || (len >= LEN_LIM)) begin
                            if (i_pkt_eop) begin
                                state_nxt = ST_RB;
                                rb_nxt    = 1'b1;
                                drop_nxt  = 1'b1;
                            end else begin
                                state_nxt = ST_DROP;
                            end
                        end else begin
                            wr_nxt  = 1'b1;
                            len_nxt = len + 1'b1;
                            if (i_pkt_eop) begin
                                commit_nxt = 1'b1;
                                state_nxt  = ST_IDLE;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (accept && i_pkt_eop) begin
                        if (counted) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_RB;
                            rb_nxt    = 1'b1;
                            drop_nxt  = 1'b1;
                        end
                    end
                end
                ST_RB:    state_nxt = ST_IDLE;
                ST_FLUSH: state_nxt = flush_to_drop ? ST_DROP : ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_w or negedge i_rst_w) begin
        if (!i_rst_w) begin
            state                 <= ST_IDLE;
            len                   <= '0;
            counted               <= 1'b0;
            flush_to_drop         <= 1'b0;
            acc_d2                <= 1'b0;
            o_fifo_write_en       <= 1'b0;
            o_fifo_data           <= '0;
            o_fifo_snapshot_wrptr <= 1'b0;
            o_fifo_rollback_wrptr <= 1'b0;
            o_fifo_reset_wrptr    <= 1'b0;
            o_pkt_commit          <= 1'b0;
            o_pkt_drop            <= 1'b0;
            o_busy                <= 1'b0;
        end else begin
            state                 <= state_nxt;
            len                   <= len_nxt;
            counted               <= counted_nxt;
            flush_to_drop         <= to_drop_nxt;
            acc_d2                <= o_fifo_write_en;
            o_fifo_write_en       <= wr_nxt;
            if (wr_nxt) o_fifo_data <= i_pkt_data;
            o_fifo_snapshot_wrptr <= snap_nxt;
            o_fifo_rollback_wrptr <= rb_nxt;
            o_fifo_reset_wrptr    <= rst_nxt;
            o_pkt_commit          <= commit_nxt;
            o_pkt_drop            <= drop_nxt;
            o_busy                <= (state_nxt != ST_IDLE);
        end
    end

    xcore_sat_cnt #(.W(CNT_W)) u_commit_cnt (
        .i_clk_w (i_clk_w),
        .i_rst_w (i_rst_w),
        .i_inc   (commit_nxt),
        .o_cnt   (o_commit_cnt)
    );

    xcore_sat_cnt #(.W(CNT_W)) u_drop_cnt (
        .i_clk_w (i_clk_w),
        .i_rst_w (i_rst_w),
        .i_inc   (drop_nxt),
        .o_cnt   (o_drop_cnt)
    );

endmodule

// File: tb/tb_xcore_fifo_pkt_wr_ctrl.sv
// Bench for xcore_fifo_pkt_wr_ctrl: scoreboard of expected FIFO writes plus a small
// FIFO occupancy/pointer model driving full and a two-cycle-lagged room status.
// Covers reset, good packet, mid-packet error, backpressure, oversize, flush, stray beat.
module tb_xcore_fifo_pkt_wr_ctrl;

    localparam int FW = 32;
    localparam int FP = 6;
    localparam int ML = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vld = 1'b0, sop = 1'b0, eop = 1'b0, err = 1'b0;
    logic [FW-1:0] dat = '0;
    logic          rdy;
    logic          flush = 1'b0;
    logic          fifo_full;
    logic [FP:0]   room;
    logic          wr_en, snap, rb, wrst, commit, drop, busy;
    logic [FW-1:0] fdat;
    logic [CW-1:0] commit_cnt, drop_cnt;

    always #5 clk = ~clk;

    xcore_fifo_pkt_wr_ctrl #(
        .FIFO_WIDTH(FW), .FIFO_PTR(FP), .MAX_PKT_LEN(ML), .CNT_W(CW)
    ) dut (
        .i_clk_w               (clk),
        .i_rst_w               (rst_n),
        .i_pkt_valid           (vld),
        .i_pkt_sop             (sop),
        .i_pkt_eop             (eop),
        .i_pkt_err             (err),
        .i_pkt_data            (dat),
        .o_pkt_ready           (rdy),
        .i_flush               (flush),
        .i_fifo_full           (fifo_full),
        .i_fifo_room_avail     (room),
        .o_fifo_write_en       (wr_en),
        .o_fifo_data           (fdat),
        .o_fifo_snapshot_wrptr (snap),
        .o_fifo_rollback_wrptr (rb),
        .o_fifo_reset_wrptr    (wrst),
        .o_pkt_commit          (commit),
        .o_pkt_drop            (drop),
        .o_commit_cnt          (commit_cnt),
        .o_drop_cnt            (drop_cnt),
        .o_busy                (busy)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // FIFO model: reader stalled, room = cap - occupancy, visible two cycles after a write.
    int   cap = 0;
    int   occ = 0;
    int   snap_occ = 0;
    logic drain = 1'b0;

    assign fifo_full = (occ >= (1 << FP));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= 0;
            snap_occ <= 0;
            room     <= '0;
        end else begin
            room <= (cap > occ) ? (FP+1)'(cap - occ) : '0;
            if (drain)       occ <= 0;
            else if (wrst)   occ <= 0;
            else if (rb)     occ <= snap_occ;
            else if (wr_en) begin
                if (snap) snap_occ <= occ;
                occ <= occ + 1;
            end
        end
    end

    typedef struct packed {
        logic          commit;
        logic          snap;
        logic [FW-1:0] dat;
    } exp_t;
    exp_t q[$];

    int wr_seen = 0, commit_seen = 0, rb_seen = 0, rst_seen = 0;
    int last_snap_occ = -1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                wr_seen++;
                if (snap) last_snap_occ = occ;
                if (q.size() == 0) chk("wr_unexpected", {commit, snap, fdat}, 64'hdead);
                else               chk("wr_beat", {commit, snap, fdat}, q.pop_front());
            end else if (commit || snap) begin
                chk("pulse_without_write", {commit, snap}, 0);
            end
            if (commit) commit_seen++;
            if (wrst)   rst_seen++;
            if (rb) begin
                rb_seen++;
                chk("rb_isolated", {wr_en, snap}, 0);
            end
        end
    end

    task automatic send_beat(input logic s, input logic e, input logic r, input logic [FW-1:0] d,
                             input logic exp_wr, input logic exp_snap, input logic exp_commit);
        int w = 0;
        @(negedge clk);
        vld = 1'b1; sop = s; eop = e; err = r; dat = d;
        while (!rdy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!rdy) begin
            chk("ready_timeout", rdy, 1);
            vld = 1'b0;
            return;
        end
        if (exp_wr) q.push_back({exp_commit, exp_snap, d});
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        vld = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_drain();
        @(negedge clk); drain = 1'b1;
        @(negedge clk); drain = 1'b0;
    endtask

    int wr0, drop0, commit0, rb0, rst0, pre;
    int ov_wr, ov_commit, ov_drop;

    initial begin
        // Reset and startup
        repeat (3) @(negedge clk);
        chk("rst_wr_en", {wr_en, snap, rb, wrst}, 0);
        chk("rst_pulses", {commit, drop, busy}, 0);
        chk("rst_counts", {commit_cnt, drop_cnt}, 0);
        chk("rst_ready", rdy, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("ready_room0", rdy, 0);
        cap = 64;
        repeat (3) @(negedge clk);
        chk("ready_room64", rdy, 1);

        // Good 4-beat packet
        for (int i = 0; i < 4; i++)
            send_beat(i == 0, i == 3, 1'b0, 32'h11 + i, 1'b1, i == 0, i == 3);
        idle(6);
        chk("good_q_empty", q.size(), 0);
        chk("good_commit_cnt", commit_cnt, 1);
        chk("good_commit_pulses", commit_seen, 1);

        // Error on beat 3 of 6
        pre = occ; wr0 = wr_seen;
        send_beat(1'b1, 1'b0, 1'b0, 32'h21, 1'b1, 1'b1, 1'b0);
        send_beat(1'b0, 1'b0, 1'b0, 32'h22, 1'b1, 1'b0, 1'b0);
        send_beat(1'b0, 1'b0, 1'b1, 32'h23, 1'b0, 1'b0, 1'b0);
        send_beat(1'b0, 1'b0, 1'b0, 32'h24, 1'b0, 1'b0, 1'b0);
        send_beat(1'b0, 1'b0, 1'b0, 32'h25, 1'b0, 1'b0, 1'b0);
        send_beat(1'b0, 1'b1, 1'b0, 32'h26, 1'b0, 1'b0, 1'b0);
        idle(6);
        chk("err_writes", wr_seen - wr0, 2);
        chk("err_drop_cnt", drop_cnt, 1);
        chk("err_rb_pulses", rb_seen, 1);
        chk("err_busy", busy, 0);
        send_beat(1'b1, 1'b1, 1'b0, 32'h31, 1'b1, 1'b1, 1'b1);
        idle(4);
        chk("err_next_snap_ptr", last_snap_occ, pre);
        chk("err_commit_cnt", commit_cnt, 2);

        // Backpressure: room 2, reader stalled, then room 10
        do_drain();
        cap = 2;
        idle(4);
        wr0 = wr_seen;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send_beat(i == 0, i == 4, 1'b0, 32'h41 + i, 1'b1, i == 0, i == 4);
            end
            begin
                repeat (12) @(negedge clk);
                chk("bp_two_writes", wr_seen - wr0, 2);
                chk("bp_ready_low", rdy, 0);
                cap = 10;
            end
        join
        idle(6);
        chk("bp_all_writes", wr_seen - wr0, 5);
        chk("bp_q_empty", q.size(), 0);
        chk("bp_commit_cnt", commit_cnt, 3);

        // 12-beat packet against an 8-beat limit (when compiled in)
`ifdef XCORE_PKT_MAXLEN_CHK_EN
        ov_wr = 8; ov_commit = 0; ov_drop = 1;
`else
        ov_wr = 12; ov_commit = 1; ov_drop = 0;
`endif
        do_drain();
        cap = 64;
        idle(4);
        wr0 = wr_seen; commit0 = commit_cnt; drop0 = drop_cnt; rb0 = rb_seen;
        for (int i = 0; i < 12; i++)
            send_beat(i == 0, i == 11, 1'b0, 32'h50 + i, i < ov_wr, i == 0,
                      (ov_commit == 1) && (i == 11));
        idle(6);
        chk("ov_writes", wr_seen - wr0, ov_wr);
        chk("ov_commit_cnt", commit_cnt, commit0 + ov_commit);
        chk("ov_drop_cnt", drop_cnt, drop0 + ov_drop);
        chk("ov_rb_pulses", rb_seen - rb0, ov_drop);

        // Flush during PKT
        do_drain();
        idle(4);
        wr0 = wr_seen; drop0 = drop_cnt; rb0 = rb_seen; rst0 = rst_seen;
        send_beat(1'b1, 1'b0, 1'b0, 32'h61, 1'b1, 1'b1, 1'b0);
        send_beat(1'b0, 1'b0, 1'b0, 32'h62, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        vld = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_reset_pulse", wrst, 1);
        @(negedge clk);
        chk("flush_reset_once", rst_seen - rst0, 1);
        chk("flush_drop_cnt", drop_cnt, drop0 + 1);
        chk("flush_busy_drop", busy, 1);
        send_beat(1'b0, 1'b0, 1'b0, 32'h63, 1'b0, 1'b0, 1'b0);
        send_beat(1'b0, 1'b1, 1'b0, 32'h64, 1'b0, 1'b0, 1'b0);
        idle(4);
        chk("flush_drop_after", drop_cnt, drop0 + 1);
        chk("flush_no_rb", rb_seen - rb0, 0);
        chk("flush_writes", wr_seen - wr0, 2);
        chk("flush_idle", busy, 0);

        // Stray non-SOP beat in IDLE
        wr0 = wr_seen; drop0 = drop_cnt;
        send_beat(1'b0, 1'b1, 1'b0, 32'h77, 1'b0, 1'b0, 1'b0);
        idle(4);
        chk("stray_drop_cnt", drop_cnt, drop0 + 1);
        chk("stray_no_write", wr_seen - wr0, 0);
        chk("final_q_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xcore_fifo_pkt_wr_ctrl.md
# xcore_fifo_pkt_wr_ctrl

Write-side packet controller for the 64-deep asynchronous FIFO (`Xcore_fifo_asyn`). It accepts framed packets from an upstream valid/ready source and drives the FIFO write port, committing each good packet atomically. It takes a write-pointer snapshot at SOP and rolls the pointer back on error, oversize or abort. It sits entirely in the FIFO write clock domain; read-side consumers act on `o_pkt_commit`, which is synchronized into their domain outside this block.

## Interface
- `FIFO_WIDTH`, default 32: data width; must equal the FIFO `FIFO_WIDTH`.
- `FIFO_PTR`, default 6: FIFO pointer width; depth is 2^`FIFO_PTR`.
- `MAX_PKT_LEN`, default 32: maximum beats per packet when the length check is compiled in; range 1..2^`FIFO_PTR`.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `i_clk_w`, in, 1: write clock.
- `i_rst_w`, in, 1: reset, asynchronous, active-low.
- `i_pkt_valid`, in, 1: upstream beat valid.
- `i_pkt_sop`, in, 1: beat is the first beat of a packet.
- `i_pkt_eop`, in, 1: beat is the last beat of a packet.
- `i_pkt_err`, in, 1: beat is corrupt.
- `i_pkt_data`, in, `FIFO_WIDTH`: beat payload.
- `o_pkt_ready`, out, 1: beat accepted when `i_pkt_valid` and `o_pkt_ready` are both high.
- `i_flush`, in, 1: one-cycle abort request; resets the FIFO write pointer.
- `i_fifo_full`, in, 1: from FIFO `o_fifo_full`.
- `i_fifo_room_avail`, in, `FIFO_PTR`+1: from FIFO `o_room_avail`.
- `o_fifo_write_en`, out, 1: to FIFO `i_write_en`.
- `o_fifo_data`, out, `FIFO_WIDTH`: to FIFO `i_data`.
- `o_fifo_snapshot_wrptr`, out, 1: to FIFO `i_snapshot_wrptr`.
- `o_fifo_rollback_wrptr`, out, 1: to FIFO `i_rollback_wrptr`.
- `o_fifo_reset_wrptr`, out, 1: to FIFO `i_reset_wrptr`.
- `o_pkt_commit`, out, 1: one-cycle pulse when a packet is committed.
- `o_pkt_drop`, out, 1: one-cycle pulse when a packet is discarded.
- `o_commit_cnt`, out, `CNT_W`: saturating count of committed packets.
- `o_drop_cnt`, out, `CNT_W`: saturating count of dropped packets, including protocol errors.
- `o_busy`, out, 1: high whenever the state is not IDLE.

## Operation
**States:** IDLE, PKT, DROP, RB, FLUSH.

- **IDLE**
  - An accepted SOP beat without error is written with snapshot asserted in the same FIFO cycle, so the snapshot captures the pre-packet pointer. The block sets `len=1`.
  - If that beat also has EOP, the packet commits and the state stays IDLE. Otherwise the state moves to PKT.
  - An accepted SOP beat with error is not written. The state moves to DROP, or stays IDLE with a drop pulse if EOP is also set.
  - An accepted non-SOP beat is discarded and counted as a drop.
- **PKT**
  - A good beat is written and `len` increments.
  - A good beat with EOP commits the packet and returns to IDLE.
  - A beat with error, a beat with SOP, or a beat that would make `len` exceed the limit is not written and causes an abort. The abort goes to RB if EOP is set, otherwise to DROP.
  - The limit is 2^`FIFO_PTR` beats, or `MAX_PKT_LEN` when the length check is compiled in.
- **DROP**: `o_pkt_ready=1`. Beats are discarded until the EOP beat, then the state moves to RB.
- **RB**: one cycle. `o_fifo_rollback_wrptr=1`, `o_pkt_drop=1`, `o_pkt_ready=0`. Next state is IDLE.
- **FLUSH**: one cycle. `o_fifo_reset_wrptr=1`, `o_pkt_ready=0`.
  - Entered from any state on `i_flush`, with priority over everything else.
  - An open packet is counted as a drop with no RB.
  - Next state is DROP if FLUSH was entered from PKT or DROP, otherwise IDLE.
- **Ready rule (IDLE and PKT):** `o_pkt_ready = !i_fifo_full && (i_fifo_room_avail > acc_d1 + acc_d2)`, where `acc_dN` is a beat written N cycles earlier. This covers the two-cycle lag of the FIFO room status.
- **Counters:** saturate at all-ones. `len` is `FIFO_PTR`+1 bits.

## Timing
- All outputs are registered except `o_pkt_ready`, which is combinational from state, room and the `acc` history.
- Reset values: every register and output is 0. `o_pkt_ready` is 0 because room is 0 after reset.
- Latency: an accepted beat appears on `o_fifo_write_en`/`o_fifo_data` one cycle later.
  - Snapshot is coincident with the SOP write.
  - `o_pkt_commit` is coincident with the EOP write.
  - The rollback pulse never coincides with a write, a snapshot, or the next SOP.
- A reset asserted mid-packet clears everything. The FIFO is reset on the same reset net.

## Configuration
- `XCORE_PKT_MAXLEN_CHK_EN` defined: packets longer than `MAX_PKT_LEN` beats are dropped at beat `MAX_PKT_LEN`+1.
- Macro undefined: the only length limit is 2^`FIFO_PTR` beats, which prevents deadlock on a full FIFO.

## Structure
- Package `xcore_fifo_pkg`: the state enum, `FIFO_PTR`/`FIFO_DEPTH` defaults, and the counter width.
- One sub-module, `xcore_sat_cnt`: a saturating counter with an increment input, instantiated twice.

## Test plan
- **Reset and startup:** `room_avail` steps from 0 to 64 after reset → `o_pkt_ready` stays 0 until room is non-zero; all outputs are 0 during reset.
- **Good packet:** a 4-beat packet of 0x11..0x14 with room 64 → four writes, snapshot on the first, `o_pkt_commit` on the fourth, `o_commit_cnt=1`.
- **Error mid-packet:** `i_pkt_err` on beat 3 of 6 → two writes, DROP for beats 4–6, one RB pulse, `o_drop_cnt=1`, the next SOP is snapshotted at the pre-packet pointer.
- **Backpressure:** room held at 2 and the reader stalled → at most 2 beats are written and `o_pkt_ready` drops; raising room to 10 resumes writing with no beat lost.
- **Oversize (macro on, `MAX_PKT_LEN=8`):** a 12-beat packet → 8 writes, then DROP, RB after the EOP, no commit.
- **Flush and protocol errors:** `i_flush` during PKT → `o_fifo_reset_wrptr` for one cycle, drop counted, remaining beats discarded. A stray non-SOP beat in IDLE → drop count increments and no write.
